// File: rtl/axi_rdata_xbar.sv
// AXI R-channel crossbar: routes slave read beats to the master named in RID[ID_W-1:MSEL_LSB],
// with one round-robin arbiter per master, burst locking until RLAST and an optional skid stage.
module axi_rdata_xbar #(
    parameter int NUM_S    = 3,
    parameter int NUM_M    = 2,
    parameter int ID_W     = 8,
    parameter int DATA_W   = 32,
    parameter int MSEL_LSB = 4,
    parameter int REG_OUT  = 1,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_S*ID_W-1:0]    S_RID,
    input  logic [NUM_S*DATA_W-1:0]  S_RDATA,
    input  logic [NUM_S*2-1:0]       S_RRESP,
    input  logic [NUM_S-1:0]         S_RLAST,
    input  logic [NUM_S-1:0]         S_RVALID,
    output logic [NUM_S-1:0]         S_RREADY,
    output logic [NUM_M*ID_W-1:0]    M_RID,
    output logic [NUM_M*DATA_W-1:0]  M_RDATA,
    output logic [NUM_M*2-1:0]       M_RRESP,
    output logic [NUM_M-1:0]         M_RLAST,
    output logic [NUM_M-1:0]         M_RVALID,
    input  logic [NUM_M-1:0]         M_RREADY,
    output logic [CNT_W-1:0]         drop_cnt
);
    // Handshake rule on every port: a beat moves on a rising edge where valid && ready;
    // a held valid keeps its payload stable until that edge.
    localparam int MW = ID_W - MSEL_LSB;
    localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam int PW = ID_W + DATA_W + 3;

    logic [MW-1:0]    tgt [NUM_S];
    logic [PW-1:0]    s_pl [NUM_S];
    logic [NUM_S-1:0] undec;
    logic [NUM_S-1:0] req [NUM_M];
    logic [NUM_M-1:0] lock;
    logic [SW-1:0]    owner [NUM_M];
    logic [SW-1:0]    ptr [NUM_M];
    logic [NUM_M-1:0] gnt;
    logic [SW-1:0]    gnt_idx [NUM_M];
    logic [PW-1:0]    in_pl [NUM_M];
    logic [NUM_M-1:0] in_ready;
    logic [CNT_W-1:0] drop_nxt;

    always_comb begin
        for (int s = 0; s < NUM_S; s++) begin
            tgt[s]   = S_RID[s*ID_W+MSEL_LSB +: MW];
            s_pl[s]  = {S_RID[s*ID_W +: ID_W], S_RDATA[s*DATA_W +: DATA_W], S_RRESP[s*2 +: 2], S_RLAST[s]};
            undec[s] = !rst && S_RVALID[s] && (32'(tgt[s]) >= 32'(NUM_M));
        end
        for (int m = 0; m < NUM_M; m++) begin
            for (int s = 0; s < NUM_S; s++) begin
                req[m][s] = !rst && S_RVALID[s] && (32'(tgt[s]) == 32'(m));
            end
        end
    end

    // Grant is combinational: locked masters only see their owner, otherwise scan from ptr.
    always_comb begin
        int idx;
        idx = 0;
        for (int m = 0; m < NUM_M; m++) begin
            gnt[m]     = 1'b0;
            gnt_idx[m] = '0;
            if (lock[m]) begin
                if (req[m][owner[m]]) begin
                    gnt[m]     = 1'b1;
                    gnt_idx[m] = owner[m];
                end
            end else begin
                for (int k = 0; k < NUM_S; k++) begin
                    idx = int'(ptr[m]) + k;
                    if (idx >= NUM_S) idx = idx - NUM_S;
                    if (!gnt[m] && req[m][idx]) begin
                        gnt[m]     = 1'b1;
                        gnt_idx[m] = SW'(idx);
                    end
                end
            end
            in_pl[m] = s_pl[gnt_idx[m]];
        end
    end

    always_comb begin
        S_RREADY = undec;
        for (int m = 0; m < NUM_M; m++) begin
            if (gnt[m] && in_ready[m]) S_RREADY[gnt_idx[m]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock <= '0;
            for (int m = 0; m < NUM_M; m++) begin
                owner[m] <= '0;
                ptr[m]   <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_M; m++) begin
                if (gnt[m] && in_ready[m]) begin
                    if (S_RLAST[gnt_idx[m]]) begin
                        lock[m] <= 1'b0;
                        ptr[m]  <= (32'(gnt_idx[m]) == 32'(NUM_S - 1)) ? '0 : gnt_idx[m] + 1'b1;
                    end else begin
                        lock[m]  <= 1'b1;
                        owner[m] <= gnt_idx[m];
                    end
                end
            end
        end
    end

    // Several slaves may drop in the same cycle; each one counts, saturating at all-ones.
    always_comb begin
        drop_nxt = drop_cnt;
        for (int s = 0; s < NUM_S; s++) begin
            if (undec[s] && drop_nxt != '1) drop_nxt = drop_nxt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt <= '0;
        else     drop_cnt <= drop_nxt;
    end

    if (REG_OUT == 0) begin : g_comb
        always_comb begin
            in_ready = M_RREADY;
            M_RID    = '0;
            M_RDATA  = '0;
            M_RRESP  = '0;
            M_RLAST  = '0;
            M_RVALID = gnt;
            for (int m = 0; m < NUM_M; m++) begin
                {M_RID[m*ID_W +: ID_W], M_RDATA[m*DATA_W +: DATA_W], M_RRESP[m*2 +: 2], M_RLAST[m]} =
                    gnt[m] ? in_pl[m] : '0;
            end
        end
    end else begin : g_skid
        // e0 is the head and drives the master port directly; e1 absorbs the beat
        // accepted while the head is stalled, so ready can come from a register.
        logic [1:0]       cnt [NUM_M];
        logic [PW-1:0]    e0 [NUM_M];
        logic [PW-1:0]    e1 [NUM_M];
        logic [NUM_M-1:0] push;
        logic [NUM_M-1:0] pop;

        always_comb begin
            M_RID    = '0;
            M_RDATA  = '0;
            M_RRESP  = '0;
            M_RLAST  = '0;
            M_RVALID = '0;
            in_ready = '0;
            push     = '0;
            pop      = '0;
            for (int m = 0; m < NUM_M; m++) begin
                in_ready[m] = (cnt[m] != 2'd2);
                M_RVALID[m] = (cnt[m] != 2'd0);
                push[m]     = gnt[m] && in_ready[m];
                pop[m]      = M_RVALID[m] && M_RREADY[m];
                {M_RID[m*ID_W +: ID_W], M_RDATA[m*DATA_W +: DATA_W], M_RRESP[m*2 +: 2], M_RLAST[m]} = e0[m];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int m = 0; m < NUM_M; m++) begin
                    cnt[m] <= 2'd0;
                    e0[m]  <= '0;
                    e1[m]  <= '0;
                end
            end else begin
                for (int m = 0; m < NUM_M; m++) begin
                    case (cnt[m])
                        2'd0: begin
                            if (push[m]) begin
                                e0[m]  <= in_pl[m];
                                cnt[m] <= 2'd1;
                            end
                        end
                        2'd1: begin
                            if (push[m] && pop[m]) begin
                                e0[m] <= in_pl[m];
                            end else if (push[m]) begin
                                e1[m]  <= in_pl[m];
                                cnt[m] <= 2'd2;
                            end else if (pop[m]) begin
                                cnt[m] <= 2'd0;
                            end
                        end
                        default: begin
                            if (pop[m]) begin
                                e0[m]  <= e1[m];
                                cnt[m] <= 2'd1;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/axi_rdata_xbar.md
Name: axi_rdata_xbar

Overview:
Parametrised AXI read-data (R channel) crossbar that returns slave read beats to the master encoded in the RID master field.
It generalises the fixed 3-slave/2-master R mux:
- any number of slaves and masters;
- one independent round-robin arbiter per master, so different masters are served concurrently;
- burst locking until RLAST;
- drop-and-count handling of undecodable IDs;
- an optional registered output stage.

It sits in the AXI bridge between the slave-side R ports (including the default slave) and the master-side R ports.

Parameters:
NUM_S, 3, number of slave R ports (index NUM_S-1 is the default slave by convention, no special treatment)
NUM_M, 2, number of master R ports
ID_W, 8, RID width
DATA_W, 32, RDATA width
MSEL_LSB, 4, LSB of master-select field; field is RID[ID_W-1:MSEL_LSB]
REG_OUT, 1, 0 = combinational path; 1 = per-master 2-entry skid buffer (registered M outputs)
CNT_W, 8, drop counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
S_RID  in  NUM_S*ID_W  slave RID, slave s at [s*ID_W +: ID_W]
S_RDATA  in  NUM_S*DATA_W  slave RDATA
S_RRESP  in  NUM_S*2  slave RRESP
S_RLAST  in  NUM_S  slave RLAST
S_RVALID  in  NUM_S  slave RVALID
S_RREADY  out  NUM_S  slave RREADY
M_RID  out  NUM_M*ID_W  master RID (passed unmodified)
M_RDATA  out  NUM_M*DATA_W  master RDATA
M_RRESP  out  NUM_M*2  master RRESP
M_RLAST  out  NUM_M  master RLAST
M_RVALID  out  NUM_M  master RVALID
M_RREADY  in  NUM_M  master RREADY
drop_cnt  out  CNT_W  saturating count of dropped beats (undecodable master field)

Behaviour:
Reset:
- clk is the only clock; rst is asynchronous and active-high.
- Reset clears all lock flags, zeroes all RR pointers, empties the skid buffers and zeroes drop_cnt.
- M_RVALID=0, M_RID/M_RDATA/M_RRESP/M_RLAST=0 from reset.
- S_RREADY=0 while rst is high.

Decode:
- tgt[s] = S_RID[s][ID_W-1:MSEL_LSB].
- req[m][s] = S_RVALID[s] && tgt[s]==m.
- tgt[s] >= NUM_M means undecodable: S_RREADY[s]=1 that cycle, the beat is discarded, drop_cnt increments by 1 and saturates at all-ones.

Arbitration (per master m):
- State: lock[m], owner[m], ptr[m].
- Unlocked: grant goes to the first s with req[m][s], scanning ptr[m], ptr[m]+1, … mod NUM_S. Grant is combinational, with zero cycles of arbitration latency.
- Locked: only owner[m] is eligible; other requesters wait with S_RREADY=0.
- Handshake on the granted slave with RLAST=0 and unlocked: set lock[m]=1 and owner[m]=s.
- Handshake with RLAST=1: clear lock[m] and set ptr[m]=(s+1) mod NUM_S.
- A single-beat burst never locks but still advances ptr.
- A slave is granted by at most one master per cycle because tgt is unique per slave.
- Requests to different masters proceed in the same cycle.

Datapath, REG_OUT=0:
- M_* = granted slave's signals; M_RVALID[m] = granted && S_RVALID.
- S_RREADY[s] = granted && M_RREADY[m].
- Latency 0.

Datapath, REG_OUT=1:
- Per-master 2-entry skid buffer. Input ready = buffer not full, registered (no combinational M_RREADY to S_RREADY path).
- Latency 1 cycle; sustains 1 beat/cycle under continuous M_RREADY.
- Full: S_RREADY=0 for the granted slave.
- Lock/ptr update on the slave-side handshake, not the master-side one.

Invariants:
- M_RVALID is held with stable payload until M_RREADY.
- No beat loss or duplication; beats of one burst stay contiguous on M.

Reset mid-burst:
- All state is cleared immediately and buffered beats are discarded; no recovery of a partial burst.

Test Plan:
- Single beat: S0 RID=8'h12 (m=1), data 32'hA5A5_0001, RLAST=1, M1_RREADY=1. Expected: M1_RVALID with RID 8'h12 at cycle 0 (REG_OUT=0) or cycle 1 (REG_OUT=1); M0_RVALID=0; ptr[1]=1.
- Burst lock: S1 sends a 4-beat burst to m=0 (RID=8'h03); S0 raises RVALID to m=0 at beat 2. Expected: M0 receives S1 beats 1-4 contiguously, then S0; S0_RREADY=0 until S1's RLAST handshake.
- Round-robin fairness: S0, S1 and S2 all continuously send 1-beat bursts to m=0. Expected: M0 grant order S0,S1,S2,S0,…; each slave gets 1 of every 3 beats.
- Concurrency: S0 targets m=0 and S2 targets m=1, both 4-beat bursts. Expected: with M*_RREADY=1 both complete in 4 cycles (plus 1 cycle with REG_OUT=1), interleaved in time.
- Backpressure and undecodable ID:
  - M0_RREADY toggles 1010…: every beat is delivered exactly once, in order, with stable payload during stalls.
  - S1 RID=8'h53 (field 5 ≥ NUM_M): S1_RREADY=1, no M_RVALID, drop_cnt 0→1.
- Reset mid-burst: assert rst after beat 2 of a 4-beat burst. Expected: outputs zero immediately, locks cleared; after release a new burst from another slave is granted at once.
